// File: rtl/spi_pkg.sv
// spi_pkg: state encoding and synchroniser idle levels for the SPI daisy-chain slave.
// Rev 1.0
`default_nettype none
package spi_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } spi_slv_state_t;

    localparam int SPI_DATA_W = 8;

    // Synchroniser bus bit positions, packed as {sclk, cs, mosi}
    localparam int SPI_SCLK_IDX = 2;
    localparam int SPI_CS_IDX   = 1;
    localparam int SPI_MOSI_IDX = 0;
    localparam logic [2:0] SPI_SYNC_IDLE = 3'b010;
endpackage
`default_nettype wire

// File: rtl/spi_in_sync.sv
// spi_in_sync: multi-flop synchroniser for sclk/cs/mosi with one-clk edge strobes.
// Rev 1.0
`default_nettype none
module spi_in_sync
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_i,
    input  logic cs_i,
    input  logic mosi_i,
    output logic cs_lvl_o,
    output logic mosi_lvl_o,
    output logic sclk_fall_o,
    output logic cs_fall_o,
    output logic cs_rise_o
);
    logic [2:0] sync_q [SYNC_STAGES];
    logic [1:0] prev_q;
    logic [2:0] cur;

    assign cur = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SPI_SYNC_IDLE;
            end
            prev_q <= {SPI_SYNC_IDLE[SPI_SCLK_IDX], SPI_SYNC_IDLE[SPI_CS_IDX]};
        end else begin
            sync_q[0] <= {sclk_i, cs_i, mosi_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= {cur[SPI_SCLK_IDX], cur[SPI_CS_IDX]};
        end
    end

    assign cs_lvl_o    = cur[SPI_CS_IDX];
    assign mosi_lvl_o  = cur[SPI_MOSI_IDX];
    assign sclk_fall_o = prev_q[1] & ~cur[SPI_SCLK_IDX];
    assign cs_fall_o   = prev_q[0] & ~cur[SPI_CS_IDX];
    assign cs_rise_o   = ~prev_q[0] & cur[SPI_CS_IDX];
endmodule
`default_nettype wire

// File: rtl/spi_daisy_slave.sv
// spi_daisy_slave: oversampled SPI daisy-chain receive node; SPI_DAISY_PARITY_EN adds an odd-parity bit per frame.
// Rev 1.0
`default_nettype none
module spi_daisy_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              cs_in,
    input  logic              mosi_in,
    input  logic [DATA_W-1:0] tx_data,
    output logic              dout,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);
`ifdef SPI_DAISY_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif
    localparam int              CNT_W    = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    logic cs_lvl, mosi_s, sclk_fall, cs_fall, cs_rise;

    spi_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .rst         (rst),
        .sclk_i      (sclk_in),
        .cs_i        (cs_in),
        .mosi_i      (mosi_in),
        .cs_lvl_o    (cs_lvl),
        .mosi_lvl_o  (mosi_s),
        .sclk_fall_o (sclk_fall),
        .cs_fall_o   (cs_fall),
        .cs_rise_o   (cs_rise)
    );

    spi_slv_state_t     state_q;
    logic [FRAME_W-1:0] sr_q, sr_d, load_w;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rx_data_q;
    logic               rx_valid_q, frame_err_q, busy_q, pend_q;
    logic               frame_ok;

`ifdef SPI_DAISY_PARITY_EN
    assign load_w   = {tx_data, ~^tx_data};
    assign frame_ok = (cnt_d == CNT_FULL) && (^sr_d);
`else
    assign load_w   = tx_data;
    assign frame_ok = (cnt_d == CNT_FULL);
`endif

    // Shift happens before the cs_rise evaluation when both land in one clk
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (sclk_fall) begin
            sr_d = {sr_q[FRAME_W-2:0], mosi_s};
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall || pend_q) begin
                        state_q <= SHIFT;
                        sr_q    <= load_w;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        pend_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_d;
                    if (cs_rise) begin
                        state_q <= LATCH;
                        if (frame_ok) begin
                            rx_data_q  <= sr_d[FRAME_W-1 -: DATA_W];
                            rx_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                LATCH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    // cs already low again means the next frame started during LATCH
                    pend_q  <= ~cs_lvl;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout      = sr_q[FRAME_W-1];
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
endmodule
`default_nettype wire
